// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divide path.
package div_pkg;

    localparam int unsigned DIV_XLEN  = 64;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_XLEN);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    typedef struct packed {
        logic is_signed;
        logic word;
        logic rem;
        logic q_neg;
        logic r_neg;
    } div_flags_t;

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 shift-subtract core; one quotient bit per step_en cycle.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step_en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN:0]   pr_shift, pr_diff;
    logic            ge;
    logic            unused_diff_msb;

    // Partial remainder is XLEN+1 wide: the shifted value can reach 2*divisor-1.
    always_comb begin
        pr_shift = {rem_q, quo_q[XLEN-1]};
        pr_diff  = pr_shift - {1'b0, dvs_q};
        ge       = (pr_shift >= {1'b0, dvs_q});
    end

    assign unused_diff_msb = pr_diff[XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step_en) begin
            rem_q <= ge ? pr_diff[XLEN-1:0] : pr_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencing controller: handshake, special cases, sign fix-up and held result.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_signed,
    input  logic            i_word,
    input  logic            i_rem,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);

    localparam int unsigned HALF = XLEN / 2;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{(XLEN-HALF){v[HALF-1]}}, v};
    endfunction

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    div_flags_t           flags_q, flags_d;

    logic            accept, div0, ovf;
    logic [XLEN-1:0] a_ext, b_ext, min_val, spec_sel, spec_res;
    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b, core_dividend;
    logic [XLEN-1:0] quotient, remainder, q_fix, r_fix, fix_sel, fix_res;

    assign o_ready = (state_q == IDLE) && !i_flush;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);
    assign o_res   = res_q;
    assign accept  = i_valid && o_ready;

    // Operand conditioning and special-case detection on the raw request.
    always_comb begin
        if (i_word) begin
            a_ext   = i_signed ? sext_half(i_src1[HALF-1:0]) : {{(XLEN-HALF){1'b0}}, i_src1[HALF-1:0]};
            b_ext   = i_signed ? sext_half(i_src2[HALF-1:0]) : {{(XLEN-HALF){1'b0}}, i_src2[HALF-1:0]};
            min_val = {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            a_ext   = i_src1;
            b_ext   = i_src2;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        div0     = (b_ext == '0);
        ovf      = i_signed && (a_ext == min_val) && (b_ext == '1);
        spec_sel = div0 ? (i_rem ? a_ext : '1) : (i_rem ? '0 : min_val);
        spec_res = i_word ? sext_half(spec_sel[HALF-1:0]) : spec_sel;
    end

    // Magnitudes feed the core; W dividends are pre-shifted so XLEN/2 steps suffice.
    always_comb begin
        sa            = flags_q.is_signed && a_q[XLEN-1];
        sb            = flags_q.is_signed && b_q[XLEN-1];
        abs_a         = sa ? -a_q : a_q;
        abs_b         = sb ? -b_q : b_q;
        core_dividend = flags_q.word ? {abs_a[HALF-1:0], {(XLEN-HALF){1'b0}}} : abs_a;
        q_fix         = flags_q.q_neg ? -quotient : quotient;
        r_fix         = flags_q.r_neg ? -remainder : remainder;
        fix_sel       = flags_q.rem ? r_fix : q_fix;
        fix_res       = flags_q.word ? sext_half(fix_sel[HALF-1:0]) : fix_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        res_d   = res_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d               = a_ext;
                        b_d               = b_ext;
                        flags_d.is_signed = i_signed;
                        flags_d.word      = i_word;
                        flags_d.rem       = i_rem;
                        flags_d.q_neg     = 1'b0;
                        flags_d.r_neg     = 1'b0;
                        if (div0 || ovf) begin
                            res_d   = spec_res;
                            state_d = DONE;
                        end else begin
                            state_d = PREP;
                        end
                    end
                end
                PREP: begin
                    flags_d.q_neg = sa ^ sb;
                    flags_d.r_neg = sa;
                    cnt_d   = flags_q.word ? DIV_CNT_W'(HALF - 1) : DIV_CNT_W'(XLEN - 1);
                    state_d = ITER;
                end
                ITER: begin
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    res_d   = fix_res;
                    state_d = DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            res_q   <= res_d;
        end
    end

    div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (state_q == PREP),
        .step_en   (state_q == ITER),
        .dividend  (core_dividend),
        .divisor   (abs_b),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected result and latency queued at accept.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_signed, i_word, i_rem, i_flush, i_ready;
    logic [63:0] i_src1, i_src2;
    logic        o_ready, o_valid, o_busy;
    logic [63:0] o_res;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_ctrl #(
        .XLEN (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_src1   (i_src1),
        .i_src2   (i_src2),
        .i_signed (i_signed),
        .i_word   (i_word),
        .i_rem    (i_rem),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_res    (o_res),
        .o_busy   (o_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference divider built on the language's signed/unsigned / and % operators.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic sg, input logic wd, input logic rm,
                                            output int lat);
        logic [31:0]        r32;
        logic [63:0]        r64;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa64, sb64;
        lat = wd ? 35 : 67;
        if (wd) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'd0) begin
                lat = 1;
                r32 = rm ? a[31:0] : 32'hFFFF_FFFF;
            end else if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                lat = 1;
                r32 = rm ? 32'd0 : 32'h8000_0000;
            end else if (sg) begin
                r32 = rm ? sa32 % sb32 : sa32 / sb32;
            end else begin
                r32 = rm ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            end
            return {{32{r32[31]}}, r32};
        end
        sa64 = a;
        sb64 = b;
        if (b == 64'd0) begin
            lat = 1;
            r64 = rm ? a : '1;
        end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
            lat = 1;
            r64 = rm ? 64'd0 : 64'h8000_0000_0000_0000;
        end else if (sg) begin
            r64 = rm ? sa64 % sb64 : sa64 / sb64;
        end else begin
            r64 = rm ? a % b : a / b;
        end
        return r64;
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sg,
                        input logic wd, input logic rm, input logic [63:0] exp_res,
                        input int exp_lat);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (!o_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("send_ready", 64'(o_ready), 64'd1);
        e.res = exp_res;
        e.lat = exp_lat;
        sb_q.push_back(e);
        i_src1   = a;
        i_src2   = b;
        i_signed = sg;
        i_word   = wd;
        i_rem    = rm;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        // Sources must be ignored while busy.
        i_src1   = {$urandom, $urandom};
        i_src2   = {$urandom, $urandom};
        i_signed = ~sg;
        i_word   = ~wd;
        i_rem    = ~rm;
    endtask

    task automatic send_model(input logic [63:0] a, input logic [63:0] b, input logic sg,
                              input logic wd, input logic rm);
        int          lat;
        logic [63:0] r;
        r = ref_div(a, b, sg, wd, rm, lat);
        send(a, b, sg, wd, rm, r, lat);
    endtask

    // Called right after the accepting edge; latency 1 means valid already.
    task automatic collect(input string tag, input int hold);
        int   lat = 1;
        exp_t e;
        while (!o_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
        check_eq({tag, "_res"}, o_res, e.res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
            check_eq({tag, "_hold_res"}, o_res, e.res);
            check_eq({tag, "_hold_ready"}, 64'(o_ready), 64'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check_eq({tag, "_retire"}, {62'd0, o_valid, o_busy}, 64'd0);
    endtask

    initial begin
        exp_t e;
        logic seen;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_src1   = '0;
        i_src2   = '0;
        i_signed = 1'b0;
        i_word   = 1'b0;
        i_rem    = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_res", o_res, 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", 64'(o_ready), 64'd1);

        send(64'd100, -64'sd7, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 67);
        collect("div_100_m7", 0);
        send(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        collect("rem_m7_2", 0);
        send(64'd7, 64'd2, 1'b0, 1'b0, 1'b1, 64'd1, 67);
        collect("remu_7_2", 0);
        send(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        collect("divuw_ones", 0);
        send(64'h8000_0000, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 35);
        collect("divuw_sext", 0);
        send(-64'sd100, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 35);
        collect("remw_m100_7", 0);

        send(64'd12345, 64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        collect("div_by0", 0);
        send(64'h1_8000_0000, 64'h7_0000_0000, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
        collect("remw_by0", 0);
        send(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1);
        collect("div_ovf", 0);
        send(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1, 64'd0, 1);
        collect("rem_ovf", 0);
        send(64'h8000_0000, '1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1);
        collect("divw_ovf", 0);

        send(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'd333, 67);
        collect("backpressure", 10);

        // Flush in the middle of iteration.
        send(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 64'd142, 67);
        e = sb_q.pop_front();
        repeat (21) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check_eq("flush_idle", {62'd0, o_valid, o_busy}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        check_eq("flush_no_valid", 64'(seen), 64'd0);
        send(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 64'd142, 67);
        collect("after_flush", 0);

        // Valid together with flush in IDLE is refused.
        @(negedge clk);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_src2  = 64'd0;
        #1;
        check_eq("flush_idle_ready", 64'(o_ready), 64'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check_eq("flush_idle_busy", {62'd0, o_valid, o_busy}, 64'd0);

        // Asynchronous reset mid-iteration.
        send(64'd999, 64'd5, 1'b0, 1'b0, 1'b0, 64'd199, 67);
        e = sb_q.pop_front();
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_outputs", {o_res[61:0], o_valid, o_busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_res", o_res, 64'd0);
        check_eq("arst_ready", 64'(o_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (o_valid || o_busy) seen = 1'b1;
        end
        check_eq("arst_quiet", 64'(seen), 64'd0);
        send(64'd999, 64'd5, 1'b0, 1'b0, 1'b0, 64'd199, 67);
        collect("after_rst", 0);

        for (int k = 0; k < 12; k++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b = 64'($urandom_range(1, 65535));
            send_model(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            collect("rand", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
